// File: rtl/wb_pkg.sv
// Package for the multi-lane write-back stage.
// Holds the per-lane MEM->WB bundle layout (lane_bus_t, LANE_BUS_W), the
// exception-vector bit indices, the ECODE/ESUBCODE constants and the TID CSR
// address used when an instruction reads the counter ID implicitly.
package wb_pkg;

    localparam int WB_PC_W   = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;
    localparam int WB_CSR_AW = 14;
    localparam int WB_EXC_W  = 17;

    // Exception vector bit indices; higher index = higher priority.
    localparam int EXC_TLBR = 0;
    localparam int EXC_FPE  = 1;
    localparam int EXC_FPD  = 2;
    localparam int EXC_IPE  = 3;
    localparam int EXC_INE  = 4;
    localparam int EXC_BRK  = 5;
    localparam int EXC_SYS  = 6;
    localparam int EXC_ALE  = 7;
    localparam int EXC_ADEM = 8;
    localparam int EXC_ADEF = 9;
    localparam int EXC_PPI  = 10;
    localparam int EXC_PME  = 11;
    localparam int EXC_PIF  = 12;
    localparam int EXC_PIS  = 13;
    localparam int EXC_PIL  = 14;
    localparam int EXC_INT  = 15;
    localparam int EXC_ERTN = 16;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_FPD  = 6'h0F;
    localparam logic [5:0] ECODE_FPE  = 6'h12;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam logic [8:0] ESUB_ADEF = 9'd0;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    localparam logic [WB_CSR_AW-1:0] CSR_TID = 14'h040;

    // One lane of the MEM->WB bundle. csr_wmask is all-ones for csrwr and the
    // rj mask for csrxchg; bits outside the mask keep the old CSR value.
    typedef struct packed {
        logic                 valid;
        logic [WB_PC_W-1:0]   pc;
        logic                 kernel_inst;
        logic [WB_EXC_W-1:0]  exc_type;
        logic [WB_PC_W-1:0]   mem_addr;
        logic                 rf_we;
        logic [WB_REG_AW-1:0] rf_waddr;
        logic [WB_DATA_W-1:0] rf_wdata;
        logic                 wdata_src;
        logic                 csr_we;
        logic                 raddr_src;
        logic [WB_CSR_AW-1:0] csr_addr;
        logic [WB_DATA_W-1:0] csr_wdata;
        logic [WB_DATA_W-1:0] csr_wmask;
        logic                 llbit_we;
        logic                 llbit_wdata;
    } lane_bus_t;

    localparam int LANE_BUS_W     = $bits(lane_bus_t);
    localparam int LANE_VALID_BIT = LANE_BUS_W - 1;

endpackage

// File: rtl/wb_multi_lane_commit_excep_dec.sv
// wb_lane_excep_dec: per-lane exception cause decoder.
// Ports: lane_valid, kernel_inst, cpu_level, exc_type, pc, mem_addr in;
//        exc, ertn, ecode, esubcode, badv_we, badv out.
// Picks the highest-priority cause; a kernel-only instruction at PLV3 is
// folded in as IPE. BADV is the PC for ADEF and the data address for ALE.
module wb_lane_excep_dec
    import wb_pkg::*;
#(
    parameter int PC_W  = WB_PC_W,
    parameter int EXC_W = WB_EXC_W
) (
    input  logic            lane_valid,
    input  logic            kernel_inst,
    input  logic [1:0]      cpu_level,
    input  logic [EXC_W-1:0] exc_type,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] mem_addr,
    output logic            exc,
    output logic            ertn,
    output logic [5:0]      ecode,
    output logic [8:0]      esubcode,
    output logic            badv_we,
    output logic [PC_W-1:0] badv
);

    logic [15:0] cause;

    always_comb begin
        cause = exc_type[15:0];
        if (cpu_level == 2'd3 && kernel_inst) cause[EXC_IPE] = 1'b1;
    end

    assign exc  = lane_valid & (|cause);
    assign ertn = lane_valid & exc_type[EXC_ERTN];

    always_comb begin
        ecode    = '0;
        esubcode = '0;
        badv_we  = 1'b0;
        badv     = '0;
        if (cause[EXC_INT])       ecode = ECODE_INT;
        else if (cause[EXC_PIL])  ecode = ECODE_PIL;
        else if (cause[EXC_PIS])  ecode = ECODE_PIS;
        else if (cause[EXC_PIF])  ecode = ECODE_PIF;
        else if (cause[EXC_PME])  ecode = ECODE_PME;
        else if (cause[EXC_PPI])  ecode = ECODE_PPI;
        else if (cause[EXC_ADEF]) begin
            ecode    = ECODE_ADE;
            esubcode = ESUB_ADEF;
            badv_we  = 1'b1;
            badv     = pc;
        end
        else if (cause[EXC_ADEM]) begin
            ecode    = ECODE_ADE;
            esubcode = ESUB_ADEM;
        end
        else if (cause[EXC_ALE]) begin
            ecode   = ECODE_ALE;
            badv_we = 1'b1;
            badv    = mem_addr;
        end
        else if (cause[EXC_SYS])  ecode = ECODE_SYS;
        else if (cause[EXC_BRK])  ecode = ECODE_BRK;
        else if (cause[EXC_INE])  ecode = ECODE_INE;
        else if (cause[EXC_IPE])  ecode = ECODE_IPE;
        else if (cause[EXC_FPD])  ecode = ECODE_FPD;
        else if (cause[EXC_FPE])  ecode = ECODE_FPE;
        else if (cause[EXC_TLBR]) ecode = ECODE_TLBR;
    end

endmodule

// File: rtl/wb_multi_lane_commit.sv
// wb_multi_lane_commit: N-lane write-back / commit stage.
// Registers the MEM->WB bundle and commits lanes in program order (lane 0
// oldest). The first lane with an exception or ERTN and every younger lane
// are killed; that lane drives the exception/ERTN commit and the flush.
// Ports: clk, rst_n; mw_valid_i/mw_to_ibus/wb_allowin_o (MEM side);
//   rfb_allowin_i/wb_to_rfb_valid_o/wb_flush_o (downstream);
//   csr_rdata_i/csr_raddr_o, cpu_level_i; regs_we/waddr/wdata per lane;
//   single CSR and llbit write ports; excep_* / ertn_en_o; to_debug_obus.
// Handshake: a bundle moves MEM->WB when mw_valid_i & wb_allowin_o (and no
//   flush); it commits when valid_q & rfb_allowin_i ("fire"). Every side
//   effect is qualified by fire, so a stalled bundle writes exactly once.
// Optional: define WB_PERF_CNT_EN for a 64-bit retired-lane counter
//   (perf_retired_o).
module wb_multi_lane_commit
    import wb_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int PC_W   = WB_PC_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int CSR_AW = WB_CSR_AW,
    parameter int EXC_W  = WB_EXC_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  mw_valid_i,
    input  logic [LANES*LANE_BUS_W-1:0]           mw_to_ibus,
    output logic                                  wb_allowin_o,
    input  logic                                  rfb_allowin_i,
    output logic                                  wb_to_rfb_valid_o,
    output logic                                  wb_flush_o,
    input  logic [DATA_W-1:0]                     csr_rdata_i,
    input  logic [1:0]                            cpu_level_i,
    output logic [CSR_AW-1:0]                     csr_raddr_o,
    output logic [LANES-1:0]                      regs_we_o,
    output logic [LANES*REG_AW-1:0]               regs_waddr_o,
    output logic [LANES*DATA_W-1:0]               regs_wdata_o,
    output logic                                  csr_we_o,
    output logic [CSR_AW-1:0]                     csr_waddr_o,
    output logic [DATA_W-1:0]                     csr_wdata_o,
    output logic                                  llbit_we_o,
    output logic                                  llbit_wdata_o,
    output logic                                  excep_en_o,
    output logic                                  ertn_en_o,
    output logic [5:0]                            excep_ecode_o,
    output logic [8:0]                            excep_esubcode_o,
    output logic [PC_W-1:0]                       excep_pc_o,
    output logic                                  excep_badv_we_o,
    output logic [PC_W-1:0]                       excep_badv_o,
`ifdef WB_PERF_CNT_EN
    output logic [63:0]                           perf_retired_o,
`endif
    output logic [LANES*(1+REG_AW+DATA_W+PC_W)-1:0] to_debug_obus
);

    localparam int DBG_W = 1 + REG_AW + DATA_W + PC_W;

    logic                        valid_q;
    logic [LANES*LANE_BUS_W-1:0] bundle_q;
    logic                        fire;
    logic                        flush;

    lane_bus_t        lane     [LANES];
    logic [LANES-1:0] exc;
    logic [LANES-1:0] ertn;
    logic [5:0]       dec_ecode [LANES];
    logic [8:0]       dec_esub  [LANES];
    logic [LANES-1:0] dec_badv_we;
    logic [PC_W-1:0]  dec_badv  [LANES];
    logic [LANES-1:0] commit;

    logic              hit_exc, hit_ertn, hit_badv_we;
    logic [5:0]        hit_ecode;
    logic [8:0]        hit_esub;
    logic [PC_W-1:0]   hit_pc, hit_badv;
    logic              csr_found, csr_commit;
    logic              sel_csr_we, sel_llbit_we, sel_llbit_wdata, sel_raddr_src;
    logic [CSR_AW-1:0] sel_csr_addr;
    logic [DATA_W-1:0] sel_csr_wdata, sel_csr_wmask;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [DATA_W-1:0] wdata;

            assign lane[g] = lane_bus_t'(bundle_q[g*LANE_BUS_W +: LANE_BUS_W]);

            wb_lane_excep_dec #(.PC_W(PC_W), .EXC_W(EXC_W)) u_dec (
                .lane_valid  (lane[g].valid),
                .kernel_inst (lane[g].kernel_inst),
                .cpu_level   (cpu_level_i),
                .exc_type    (lane[g].exc_type),
                .pc          (lane[g].pc),
                .mem_addr    (lane[g].mem_addr),
                .exc         (exc[g]),
                .ertn        (ertn[g]),
                .ecode       (dec_ecode[g]),
                .esubcode    (dec_esub[g]),
                .badv_we     (dec_badv_we[g]),
                .badv        (dec_badv[g])
            );

            assign wdata = lane[g].wdata_src ? csr_rdata_i : lane[g].rf_wdata;
            assign regs_we_o[g] = fire & commit[g] & lane[g].rf_we;
            assign regs_waddr_o[g*REG_AW +: REG_AW] = lane[g].rf_waddr;
            assign regs_wdata_o[g*DATA_W +: DATA_W] = wdata;
            assign to_debug_obus[g*DBG_W +: DBG_W] =
                {regs_we_o[g], lane[g].rf_waddr, wdata, lane[g].pc};
        end
    endgenerate

    // Kill mask, exception source and CSR-lane select, scanned oldest first.
    always_comb begin
        logic seen;
        seen            = 1'b0;
        commit          = '0;
        hit_exc         = 1'b0;
        hit_ertn        = 1'b0;
        hit_ecode       = '0;
        hit_esub        = '0;
        hit_pc          = '0;
        hit_badv_we     = 1'b0;
        hit_badv        = '0;
        csr_found       = 1'b0;
        csr_commit      = 1'b0;
        sel_csr_we      = 1'b0;
        sel_llbit_we    = 1'b0;
        sel_llbit_wdata = 1'b0;
        sel_raddr_src   = 1'b0;
        sel_csr_addr    = '0;
        sel_csr_wdata   = '0;
        sel_csr_wmask   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!seen && (exc[i] || ertn[i])) begin
                hit_exc     = exc[i];
                hit_ertn    = ertn[i] & ~exc[i];  // exception beats ERTN
                hit_ecode   = dec_ecode[i];
                hit_esub    = dec_esub[i];
                hit_pc      = lane[i].pc;
                hit_badv_we = dec_badv_we[i];
                hit_badv    = dec_badv[i];
            end
            commit[i] = lane[i].valid & ~seen & ~exc[i] & ~ertn[i];
            seen = seen | exc[i] | ertn[i];
            if (!csr_found && lane[i].valid &&
                (lane[i].csr_we || lane[i].llbit_we || lane[i].raddr_src || lane[i].wdata_src)) begin
                csr_found       = 1'b1;
                csr_commit      = commit[i];
                sel_csr_we      = lane[i].csr_we;
                sel_llbit_we    = lane[i].llbit_we;
                sel_llbit_wdata = lane[i].llbit_wdata;
                sel_raddr_src   = lane[i].raddr_src;
                sel_csr_addr    = lane[i].csr_addr;
                sel_csr_wdata   = lane[i].csr_wdata;
                sel_csr_wmask   = lane[i].csr_wmask;
            end
        end
    end

    assign fire              = valid_q & rfb_allowin_i;
    assign wb_allowin_o      = ~valid_q | rfb_allowin_i;
    assign wb_to_rfb_valid_o = valid_q;
    assign excep_en_o        = fire & hit_exc;
    assign ertn_en_o         = fire & hit_ertn;
    assign flush             = excep_en_o | ertn_en_o;
    assign wb_flush_o        = flush;
    assign excep_ecode_o     = excep_en_o ? hit_ecode : '0;
    assign excep_esubcode_o  = excep_en_o ? hit_esub : '0;
    assign excep_pc_o        = flush ? hit_pc : '0;
    assign excep_badv_we_o   = excep_en_o & hit_badv_we;
    assign excep_badv_o      = excep_badv_we_o ? hit_badv : '0;

    assign csr_raddr_o   = !valid_q ? '0 : ((csr_found && sel_raddr_src) ? sel_csr_addr : CSR_TID);
    assign csr_we_o      = fire & csr_commit & sel_csr_we;
    assign csr_waddr_o   = sel_csr_addr;
    assign csr_wdata_o   = csr_found ? ((sel_csr_wdata & sel_csr_wmask) | (csr_rdata_i & ~sel_csr_wmask)) : '0;
    assign llbit_we_o    = fire & csr_commit & sel_llbit_we;
    assign llbit_wdata_o = sel_llbit_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            if (flush)             valid_q <= 1'b0;
            else if (wb_allowin_o) valid_q <= mw_valid_i;
            if (mw_valid_i && wb_allowin_o && !flush) bundle_q <= mw_to_ibus;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [63:0] perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    perf_q <= '0;
        else if (fire) perf_q <= perf_q + 64'($countones(commit));
    end
    assign perf_retired_o = perf_q;
`endif

endmodule
